collapse_buffer: RTL and testbench
==================================

// Module: collapse_buffer
//
// PURPOSE
//   Age-ordered, collapsing entry buffer that feeds a bit-vector selector
//   (MODE=1, ACT=HIGH, MSB=DISABLE). Slot 0 always holds the oldest live
//   entry, so lowest-index selection equals oldest-ready selection.
//   The selector's one-hot pos output returns as grant and retires that slot.
//   Higher slots shift down one place to keep the buffer contiguous.
//
// PARAMETERS
//   DATA   8   width of one entry payload
//   DEPTH  8   number of slots (>=2)
//   CNTW   $clog2(DEPTH+1)   occupancy counter width (derived, do not override)
//
// PORTS
//   clk        in   1           clock, all state updates on rising edge
//   reset      in   1           synchronous, active-high reset
//   flush      in   1           synchronous clear of all entries
//   we         in   1           write request; accepted when we && wready
//   wdata      in   DATA        payload written at tail
//   wready     out  1           buffer not full (registered)
//   re         in   1           retire request for slot indicated by grant
//   grant      in   DEPTH       one-hot slot select (selector pos output)
//   valid_vec  out  DEPTH       per-slot valid, active high -> selector sel
//   entry_data out  DEPTH*DATA  per-slot payload, [DEPTH-1:0][DATA-1:0] -> selector in
//   count      out  CNTW        number of valid slots
//   empty      out  1           count == 0
//   full       out  1           count == DEPTH
//
// BEHAVIOUR
//   - Reset or flush: valid_vec=0, count=0, empty=1, full=0, wready=1.
//     entry_data is cleared to 0. Reset has priority over flush.
//     Flush has priority over we and re in the same cycle.
//   - Invariant: valid_vec is always thermometer (slots 0..count-1 valid).
//     full = (count==DEPTH); wready = !full. All outputs are registered.
//   - Retire: rm = re && |(grant & valid_vec). Only the lowest set bit of
//     grant is honoured (idx k). grant on an invalid slot or grant==0 -> no-op.
//   - On retire of k: slot i takes slot i+1 for k<=i<count-1.
//     Slot count-1 is invalidated. Slots below k are unchanged.
//   - Write: wr = we && wready. New entry goes to slot count.
//   - Simultaneous wr && rm: the shift happens first, then the write lands
//     at slot count-1. count is unchanged.
//   - A write while full is dropped with no state change. wready does not
//     look ahead at a same-cycle retire; there is no comb path from re/grant
//     to wready.
//   - count update: +1 on wr only, -1 on rm only, 0 on both or neither.
//     No wrap: count cannot exceed DEPTH or go below 0.
//   - Latency:
//     * A written entry is visible on valid_vec/entry_data the next cycle.
//     * A retired slot disappears the next cycle.
//     * No same-cycle bypass from wdata to entry_data.
//   - Invalid slots hold 0 on entry_data (a shift fills the vacated top slot with 0).
//   - Empty buffer with re asserted: no-op, no underflow.
//
// TESTING
//   1 Reset with we=1 held: after release valid_vec=0, count=0, empty=1.
//     Write A,B,C on 3 cycles -> valid_vec=8'b0000_0111, slots 0..2 = A,B,C.
//   2 With A,B,C loaded, re=1, grant=8'b0000_0010 -> next cycle slots
//     0..1 = A,C, slot 2 = 0, count=2.
//   3 With A,C loaded, we=1 (wdata=D) and re=1, grant=8'b01 in the same cycle
//     -> slots 0..1 = C,D, count stays 2.
//   4 Fill 8 entries -> full=1, wready=0. A further we (E) is dropped.
//     Then retire with grant=8'b1000_0000 -> count=7, full=0 next cycle.
//   5 re=1 with grant=8'b0110_0000 and count=3 -> no-op. Then
//     grant=8'b0000_0110 -> only slot 1 retired.
//   6 5 entries loaded; flush=1 with we=1, re=1 in the same cycle
//     -> next cycle count=0, valid_vec=0, entry_data=0.

Source files
------------

// File: rtl/collapse_buffer.sv
// Age-ordered collapsing entry buffer: slot 0 holds the oldest live entry.
// A granted slot retires and every younger entry shifts down one place.
module collapse_buffer #(
   parameter int DATA = 8,
   parameter int DEPTH = 8,
   localparam int CNTW = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        we,
   input  logic [DATA-1:0]             wdata,
   output logic                        wready,
   input  logic                        re,
   input  logic [DEPTH-1:0]            grant,
   output logic [DEPTH-1:0]            valid_vec,
   output logic [DEPTH-1:0][DATA-1:0]  entry_data,
   output logic [CNTW-1:0]             count,
   output logic                        empty,
   output logic                        full
);

   localparam int IDXW = $clog2(DEPTH);

   logic [DEPTH-1:0][DATA-1:0] shifted;
   logic [DEPTH-1:0][DATA-1:0] nxt_data;
   logic [DEPTH-1:0]           nxt_valid;
   logic [IDXW-1:0]            k;
   logic [CNTW-1:0]            widx;
   logic [CNTW-1:0]            nxt_count;
   logic                       rm;
   logic                       wr;

   // Lowest set grant bit wins; thermometer valid makes it the oldest granted.
   always_comb begin
      k = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (grant[i]) k = IDXW'(i);
      end
   end

   always_comb begin
      rm = re && |(grant & valid_vec);
      wr = we && wready;
      widx = rm ? count - CNTW'(1) : count;
      nxt_count = count + CNTW'(wr) - CNTW'(rm);
   end

   always_comb begin
      shifted[DEPTH-1] = '0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         shifted[i] = entry_data[i+1];
      end
   end

   // Shift first, then the new entry lands at the post-shift tail.
   always_comb begin
      nxt_data = entry_data;
      nxt_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rm && IDXW'(i) >= k) nxt_data[i] = shifted[i];
         if (wr && CNTW'(i) == widx) nxt_data[i] = wdata;
         nxt_valid[i] = CNTW'(i) < nxt_count;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         entry_data <= '0;
         valid_vec  <= '0;
         count      <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         wready     <= 1'b1;
      end else begin
         entry_data <= nxt_data;
         valid_vec  <= nxt_valid;
         count      <= nxt_count;
         empty      <= nxt_count == '0;
         full       <= nxt_count == CNTW'(DEPTH);
         wready     <= nxt_count != CNTW'(DEPTH);
      end
   end

endmodule

// File: tb/tb_collapse_buffer.sv
// Randomized bench for collapse_buffer against a queue-based age model.
// Directed scenarios first, then a long random run.
module tb_collapse_buffer;

   localparam int DATA = 8;
   localparam int DEPTH = 8;
   localparam int CNTW = $clog2(DEPTH + 1);

   logic                       clk;
   logic                       reset;
   logic                       flush;
   logic                       we;
   logic [DATA-1:0]            wdata;
   logic                       wready;
   logic                       re;
   logic [DEPTH-1:0]           grant;
   logic [DEPTH-1:0]           valid_vec;
   logic [DEPTH-1:0][DATA-1:0] entry_data;
   logic [CNTW-1:0]            count;
   logic                       empty;
   logic                       full;

   int checks = 0;
   int errors = 0;
   logic [DATA-1:0] mq[$];

   collapse_buffer #(.DATA(DATA), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .we(we), .wdata(wdata), .wready(wready),
      .re(re), .grant(grant), .valid_vec(valid_vec),
      .entry_data(entry_data), .count(count),
      .empty(empty), .full(full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic compare_all();
      logic [DEPTH-1:0][DATA-1:0] ed;
      ed = '0;
      for (int i = 0; i < mq.size(); i++) ed[i] = mq[i];
      chk("count", 64'(count), 64'(mq.size()));
      chk("valid_vec", 64'(valid_vec), (64'd1 << mq.size()) - 64'd1);
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("wready", 64'(wready), 64'(mq.size() != DEPTH));
      chk("entry_data", 64'(entry_data), 64'(ed));
   endtask

   // Drive one cycle from the negedge, advance the model, compare next negedge.
   task automatic step(input logic r, input logic f, input logic w,
                       input logic [DATA-1:0] d, input logic e,
                       input logic [DEPTH-1:0] g);
      int k;
      int sz;
      reset = r; flush = f; we = w; wdata = d; re = e; grant = g;
      if (r || f) begin
         mq.delete();
      end else begin
         sz = mq.size();
         k = -1;
         for (int i = DEPTH - 1; i >= 0; i--) if (g[i]) k = i;
         if (e && k >= 0 && k < sz) mq.delete(k);
         if (w && sz < DEPTH) mq.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; grant = '0;
      compare_all();
   endtask

   task automatic wr(input logic [DATA-1:0] d);
      step(1'b0, 1'b0, 1'b1, d, 1'b0, '0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; we = 1'b0; wdata = '0;
      re = 1'b0; grant = '0;
      @(negedge clk);
      // Reset with write held
      step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, '0);
      chk("rst_valid", 64'(valid_vec), 64'h0);
      wr(8'hA1); wr(8'hB2); wr(8'hC3);
      chk("abc_valid", 64'(valid_vec), 64'h07);
      chk("abc_data", 64'(entry_data), 64'h0000_0000_00C3_B2A1);
      // Retire middle slot
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'b0000_0010);
      chk("ret1_data", 64'(entry_data), 64'h0000_0000_0000_C3A1);
      chk("ret1_count", 64'(count), 64'd2);
      // Simultaneous write and retire
      step(1'b0, 1'b0, 1'b1, 8'hD4, 1'b1, 8'b0000_0001);
      chk("wrret_data", 64'(entry_data), 64'h0000_0000_0000_D4C3);
      chk("wrret_count", 64'(count), 64'd2);
      // Fill, drop write while full, retire top slot
      for (int i = 0; i < 6; i++) wr(8'(8'h10 + i));
      chk("full_flag", 64'(full), 64'd1);
      chk("full_wready", 64'(wready), 64'd0);
      wr(8'hEE);
      chk("drop_data", 64'(entry_data), 64'h1514_1312_1110_D4C3);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'b1000_0000);
      chk("top_count", 64'(count), 64'd7);
      chk("top_full", 64'(full), 64'd0);
      // Grant on invalid slots, then multi-bit grant
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      wr(8'h31); wr(8'h32); wr(8'h33);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'b0110_0000);
      chk("noop_count", 64'(count), 64'd3);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'b0000_0110);
      chk("multi_data", 64'(entry_data), 64'h0000_0000_0000_3331);
      // Empty buffer retire
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'hFF);
      chk("empty_re", 64'(count), 64'd0);
      // Flush beats write and retire
      for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
      step(1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 8'b0000_0001);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_data", 64'(entry_data), 64'h0);
      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [DEPTH-1:0] g;
         int sel;
         sel = int'($urandom_range(0, 3));
         if (sel == 0) g = DEPTH'($urandom);
         else if (sel == 1) g = '0;
         else g = DEPTH'(1) << $urandom_range(0, DEPTH - 1);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < 55, DATA'($urandom),
              $urandom_range(0, 99) < 45, g);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
